clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_ch.sv | 89 ++++++++
 rtl/clk_div_multi.sv | 83 ++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Imported by clk_div_ch and clk_div_multi.
package clk_div_pkg;

    localparam int MAX_CH    = 8;
    localparam int CH_IDX_W  = 3;
    localparam int HALF_1HZ  = 49_999_999;

    // A channel index is usable only when it addresses an instantiated channel.
    function automatic logic ch_valid(input logic [CH_IDX_W-1:0] ch, input int n_ch);
        logic ok;
        if (int'(ch) < n_ch) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow half-period limits, output toggle
// and rising-edge tick. The shadow limit is only promoted to active on a wrap or sync.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W    = 26,
    parameter logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_1HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] active_r;
    logic [CNT_W-1:0] shadow_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] active_nxt_s;
    logic [CNT_W-1:0] shadow_nxt_s;
    logic             clk_out_nxt_s;
    logic             tick_nxt_s;
    logic             wrap_s;

    // >= rather than == so a corrupted counter still recovers at the next edge.
    assign wrap_s = (cnt_r >= active_r);

    // Next-state for counter, active limit, output level and tick.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        active_nxt_s  = active_r;
        clk_out_nxt_s = clk_out_r;
        tick_nxt_s    = 1'b0;
        if (sync) begin
            cnt_nxt_s     = '0;
            clk_out_nxt_s = 1'b0;
            active_nxt_s  = shadow_r;
        end else if (en) begin
            if (wrap_s) begin
                cnt_nxt_s     = '0;
                clk_out_nxt_s = ~clk_out_r;
                active_nxt_s  = shadow_r;
                tick_nxt_s    = ~clk_out_r;
            end else begin
                cnt_nxt_s     = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s     = cnt_r;
            clk_out_nxt_s = clk_out_r;
        end
    end

    // Shadow write; the active limit above reads the pre-write shadow on a coinciding wrap.
    always_comb begin
        if (wr_en) begin
            shadow_nxt_s = wr_data;
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            active_r  <= HALF_RST;
            shadow_r  <= HALF_RST;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            active_r  <= active_nxt_s;
            shadow_r  <= shadow_nxt_s;
            clk_out_r <= clk_out_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent square-wave dividers with a shared write port for half-periods.
// Define CLK_DIV_SYNC_EN to add a 'sync' input that re-aligns all channel phases.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                    N_CH     = 3,
    parameter int                    CNT_W    = 26,
    parameter logic [N_CH*CNT_W-1:0] HALF_DEF = {N_CH{CNT_W'(HALF_1HZ)}}
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                en,
`ifdef CLK_DIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]    wr_data,
    output logic                wr_err,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     tick
);

    logic [N_CH-1:0] wr_sel_s;
    logic            sync_s;
    logic            wr_err_nxt_s;
    logic            wr_err_r;

`ifdef CLK_DIV_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // One-hot write select; indices beyond N_CH select nothing.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en && (wr_ch == CH_IDX_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Flag writes that address a channel this build does not have.
    always_comb begin
        if (wr_en && !ch_valid(wr_ch, N_CH)) begin
            wr_err_nxt_s = 1'b1;
        end else begin
            wr_err_nxt_s = 1'b0;
        end
    end

    // Registered write-error pulse.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_err_nxt_s;
        end
    end

    assign wr_err = wr_err_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W    (CNT_W),
            .HALF_RST (HALF_DEF[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk_100MHz),
            .reset   (reset),
            .en      (en),
            .sync    (sync_s),
            .wr_en   (wr_sel_s[g]),
            .wr_data (wr_data),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule
